// File: rtl/dds_pkg.sv
// Shared DDS definitions: loader FSM states and constants common to the rotary
// front end and the tuning-word loader.
package dds_pkg;

    localparam int DDS_MAX_ADDR = 1800;
    localparam int DDS_TW_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        ALIGN
    } dds_state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: adds the applied tuning word every cycle, flags the
// carry-out as the phase wrap, and exports the accumulator MSBs as phase.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int TW_W  = DDS_TW_W,
    parameter int OUT_W = 12
) (
    input  logic             Fg_clk,
    input  logic             Reset,
    input  logic             tw_load,
    input  logic [TW_W-1:0]  tw_new,
    output logic [TW_W-1:0]  tw,
    output logic             wrap,
    output logic [OUT_W-1:0] phase
);

    logic [TW_W-1:0] acc_q, acc_d;
    logic [TW_W-1:0] tw_q, tw_d;

    // The add always uses the word held in tw_q, so a load only affects the next cycle.
    always_comb begin
        {wrap, acc_d} = {1'b0, acc_q} + {1'b0, tw_q};
        tw_d          = tw_load ? tw_new : tw_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            acc_q <= '0;
            tw_q  <= '0;
        end else begin
            acc_q <= acc_d;
            tw_q  <= tw_d;
        end
    end

    assign tw    = tw_q;
    assign phase = acc_q[TW_W-1 -: OUT_W];

endmodule

// File: rtl/dds_tuning_loader.sv
// DDS tuning-word loader: captures the frequency index, fetches its tuning word
// from a synchronous ROM and applies it on a phase wrap so the output never glitches.
module dds_tuning_loader
    import dds_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int TW_W      = DDS_TW_W,
    parameter int OUT_W     = 12,
    parameter int ROM_LAT   = 1,
    parameter int MAX_ADDR  = DDS_MAX_ADDR,
    parameter bit SYNC_LOAD = 1'b1
) (
    input  logic              Fg_clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              FreqChng,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TW_W-1:0]   rom_data,
    output logic [OUT_W-1:0]  phase,
    output logic [TW_W-1:0]   tw,
    output logic              busy,
    output logic              load_done
);

    localparam int                CNT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] MAX_IDX  = ADDR_W'(MAX_ADDR);

    dds_state_e        state_q, state_d;
    logic              pending_q, pending_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              load_done_q, load_done_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TW_W-1:0]   nxt_tw_q, nxt_tw_d;
    logic [ADDR_W-1:0] idx_clamped;
    logic              tw_load;
    logic              acc_wrap;

    assign idx_clamped = (address > MAX_IDX) ? MAX_IDX : address;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        load_done_d = 1'b0;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        nxt_tw_d    = nxt_tw_q;
        tw_load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d  = 1'b0;
                    rom_en_d   = 1'b1;
                    rom_addr_d = idx_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    nxt_tw_d = rom_data;
                    state_d  = ALIGN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ALIGN: begin
                // A zero word never wraps, so waiting for a wrap would stall forever.
                if (!SYNC_LOAD || acc_wrap || (tw == '0)) begin
                    tw_load     = 1'b1;
                    load_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request overrides any clear above: latest index wins, none is lost.
        if (FreqChng) begin
            idx_d     = idx_clamped;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            load_done_q <= load_done_d;
        end
    end

    // NOTE: pure datapath registers carry no reset; each is written before the
    // FSM ever reads it (idx under pending, cnt in REQ, nxt_tw in WAIT).
    always_ff @(posedge Fg_clk) begin
        idx_q    <= idx_d;
        cnt_q    <= cnt_d;
        nxt_tw_q <= nxt_tw_d;
    end

    dds_phase_acc #(
        .TW_W  (TW_W),
        .OUT_W (OUT_W)
    ) u_phase_acc (
        .Fg_clk  (Fg_clk),
        .Reset   (Reset),
        .tw_load (tw_load),
        .tw_new  (nxt_tw_q),
        .tw      (tw),
        .wrap    (acc_wrap),
        .phase   (phase)
    );

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign load_done = load_done_q;
    assign busy      = pending_q || (state_q != IDLE);

endmodule
